// File: rtl/perf_window_monitor_if.sv
// Result channel of perf_window_monitor: valid/ready handshake plus rate fields and threshold flags.
// The monitor drives through the master modport; the optimizer or scoreboard uses the slave modport.
interface perf_window_monitor_if;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [15:0] ipc_o;
  logic [15:0] cache_miss_pm_o;
  logic [15:0] branch_miss_pm_o;
  logic [15:0] stall_pm_o;
  logic        ipc_low_o;
  logic        cache_miss_high_o;
  logic        branch_miss_high_o;
  logic        stall_high_o;
  logic        overrun_o;

  modport master (
    output result_valid_o, ipc_o, cache_miss_pm_o, branch_miss_pm_o, stall_pm_o,
           ipc_low_o, cache_miss_high_o, branch_miss_high_o, stall_high_o, overrun_o,
    input  result_ready_i
  );

  modport slave (
    input  result_valid_o, ipc_o, cache_miss_pm_o, branch_miss_pm_o, stall_pm_o,
           ipc_low_o, cache_miss_high_o, branch_miss_high_o, stall_high_o, overrun_o,
    output result_ready_i
  );
endinterface

// File: rtl/perf_window_monitor.sv
// Windowed core performance monitor: counts event strobes per window, then derives IPC and
// per-mille rates with one shared restoring divider and publishes them with threshold flags.
module perf_window_monitor #(
  parameter int unsigned WINDOW                   = 1024,
  parameter int unsigned COUNTER_WIDTH            = 32,
  parameter int unsigned IPC_PRECISION            = 1000,
  parameter int unsigned IPC_TARGET               = 85,
  parameter int unsigned CACHE_MISS_THRESHOLD     = 15,
  parameter int unsigned BRANCH_MISS_THRESHOLD    = 10,
  parameter int unsigned PIPELINE_STALL_THRESHOLD = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [1:0]            retire_cnt_i,
  input  logic                  stall_i,
  input  logic                  cache_access_i,
  input  logic                  cache_miss_i,
  input  logic                  branch_i,
  input  logic                  branch_mispred_i,
  perf_window_monitor_if.master result
);

  localparam int unsigned CW       = COUNTER_WIDTH;
  localparam int unsigned DIV_ITER = COUNTER_WIDTH + 10;
  localparam int unsigned WIN_W    = $clog2(WINDOW);
  localparam int unsigned ITER_W   = $clog2(DIV_ITER);
  localparam int unsigned NUM_EV   = 6;

  localparam int EV_RET   = 0;
  localparam int EV_STALL = 1;
  localparam int EV_ACC   = 2;
  localparam int EV_MISS  = 3;
  localparam int EV_BR    = 4;
  localparam int EV_MISP  = 5;

  localparam logic [15:0] PM_MAX     = 16'd1000;
  localparam logic [15:0] IPC_LOW_TH = 16'(IPC_TARGET * IPC_PRECISION / 100);
  localparam logic [15:0] CACHE_TH   = 16'(CACHE_MISS_THRESHOLD * 10);
  localparam logic [15:0] BRANCH_TH  = 16'(BRANCH_MISS_THRESHOLD * 10);
  localparam logic [15:0] STALL_TH   = 16'(PIPELINE_STALL_THRESHOLD * 10);

  // The divider must be idle again before the next window closes, and the scaled
  // dividend must fit in DIV_ITER bits.
  if (WINDOW < 256 || WINDOW < 4 * DIV_ITER + 4 || IPC_PRECISION > 1024) begin : g_bad_params
    $error("perf_window_monitor: WINDOW too small or IPC_PRECISION too large");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_SNAP, ST_DIV0, ST_DIV1, ST_DIV2, ST_DIV3, ST_CMP, ST_PUB
  } state_t;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
    logic [CW:0] sum;
    sum = {1'b0, a} + (CW+1)'(b);
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

  function automatic logic [15:0] clamp_pm(input logic [DIV_ITER-1:0] q);
    return (q > DIV_ITER'(PM_MAX)) ? PM_MAX : q[15:0];
  endfunction

  logic [WIN_W-1:0] r_win_cnt;
  logic [CW-1:0]    r_cnt      [NUM_EV];
  logic [CW-1:0]    r_snap     [NUM_EV];
  logic [CW-1:0]    w_cnt_next [NUM_EV];
  logic [1:0]       w_inc      [NUM_EV];
  logic             w_win_end;

  always_comb begin
    w_inc[EV_RET]   = retire_cnt_i;
    w_inc[EV_STALL] = {1'b0, stall_i};
    w_inc[EV_ACC]   = {1'b0, cache_access_i};
    w_inc[EV_MISS]  = {1'b0, cache_miss_i};
    w_inc[EV_BR]    = {1'b0, branch_i};
    w_inc[EV_MISP]  = {1'b0, branch_mispred_i};
    for (int i = 0; i < NUM_EV; i++) w_cnt_next[i] = sat_add(r_cnt[i], w_inc[i]);
  end

  assign w_win_end = enable_i && (r_win_cnt == WIN_W'(WINDOW - 1));

  // The closing cycle's own events go straight into the snapshot; the next window starts at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order inside the block.
    if (!rst_ni) begin
      r_win_cnt <= '0;
      // NOTE: the snapshot and counter arrays are plain flops (not RAM), so they are reset
      // like any other register and never expose undefined values.
      for (int i = 0; i < NUM_EV; i++) begin
        r_cnt[i]  <= '0;
        r_snap[i] <= '0;
      end
    end else if (clear_i) begin
      r_win_cnt <= '0;
      for (int i = 0; i < NUM_EV; i++) begin
        r_cnt[i]  <= '0;
        r_snap[i] <= '0;
      end
    end else if (enable_i) begin
      if (w_win_end) begin
        r_win_cnt <= '0;
        for (int i = 0; i < NUM_EV; i++) begin
          r_snap[i] <= w_cnt_next[i];
          r_cnt[i]  <= '0;
        end
      end else begin
        r_win_cnt <= r_win_cnt + WIN_W'(1);
        for (int i = 0; i < NUM_EV; i++) r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  state_t              r_state;
  logic [ITER_W-1:0]   r_iter;
  logic [CW-1:0]       r_rem;
  logic [DIV_ITER-1:0] r_quo;
  logic [CW-1:0]       r_den;
  logic                r_dvz;
  logic [DIV_ITER-1:0] r_quot [4];

  logic [1:0]          w_div_idx;
  logic [1:0]          w_next_idx;
  logic [CW-1:0]       w_num;
  logic [CW-1:0]       w_den;
  logic [DIV_ITER-1:0] w_scale;
  logic [DIV_ITER-1:0] w_dividend;

  always_comb begin
    w_div_idx = 2'd0;
    unique case (r_state)
      ST_DIV1: w_div_idx = 2'd1;
      ST_DIV2: w_div_idx = 2'd2;
      ST_DIV3: w_div_idx = 2'd3;
      default: w_div_idx = 2'd0;
    endcase
  end

  assign w_next_idx = (r_state == ST_SNAP) ? 2'd0 : w_div_idx + 2'd1;

  // Operands for the division that is about to start, in the order ipc, cache, branch, stall.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    w_num   = '0;
    w_den   = '0;
    w_scale = DIV_ITER'(PM_MAX);
    unique case (w_next_idx)
      2'd0: begin
        w_num   = r_snap[EV_RET];
        w_den   = CW'(WINDOW);
        w_scale = DIV_ITER'(IPC_PRECISION);
      end
      2'd1: begin
        w_num = r_snap[EV_MISS];
        w_den = r_snap[EV_ACC];
      end
      2'd2: begin
        w_num = r_snap[EV_MISP];
        w_den = r_snap[EV_BR];
      end
      default: begin
        w_num = r_snap[EV_STALL];
        w_den = CW'(WINDOW);
      end
    endcase
    w_dividend = DIV_ITER'(w_num) * w_scale;
  end

  // One restoring step per cycle: dividend bits shift out of r_quo's top, quotient bits in at the bottom.
  logic [CW:0]         w_rem_sh;
  logic                w_ge;
  logic [CW-1:0]       w_rem_nx;
  logic [DIV_ITER-1:0] w_quo_nx;

  assign w_rem_sh = {r_rem, r_quo[DIV_ITER-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_den});
  assign w_rem_nx = w_ge ? (w_rem_sh[CW-1:0] - r_den) : w_rem_sh[CW-1:0];
  assign w_quo_nx = {r_quo[DIV_ITER-2:0], w_ge};

  logic [15:0] w_ipc_sat;
  logic [15:0] w_cache_pm;
  logic [15:0] w_branch_pm;
  logic [15:0] w_stall_pm;

  assign w_ipc_sat   = (|r_quot[0][DIV_ITER-1:16]) ? 16'hFFFF : r_quot[0][15:0];
  assign w_cache_pm  = clamp_pm(r_quot[1]);
  assign w_branch_pm = clamp_pm(r_quot[2]);
  assign w_stall_pm  = clamp_pm(r_quot[3]);

  logic [15:0] r_cmp_ipc, r_cmp_cache, r_cmp_branch, r_cmp_stall;
  logic [3:0]  r_cmp_flags;
  logic        r_valid, r_overrun;
  logic [15:0] r_ipc, r_cache_pm, r_branch_pm, r_stall_pm;
  logic [3:0]  r_flags;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_iter       <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_den        <= '0;
      r_dvz        <= 1'b0;
      for (int i = 0; i < 4; i++) r_quot[i] <= '0;
      r_cmp_ipc    <= '0;
      r_cmp_cache  <= '0;
      r_cmp_branch <= '0;
      r_cmp_stall  <= '0;
      r_cmp_flags  <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_ipc        <= '0;
      r_cache_pm   <= '0;
      r_branch_pm  <= '0;
      r_stall_pm   <= '0;
      r_flags      <= '0;
    end else if (clear_i) begin
      r_state   <= ST_IDLE;
      r_iter    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_win_end) r_state <= ST_SNAP;
        ST_SNAP: begin
          r_quo   <= w_dividend;
          r_rem   <= '0;
          r_den   <= w_den;
          r_dvz   <= (w_den == '0);
          r_iter  <= '0;
          r_state <= ST_DIV0;
        end
        ST_DIV0, ST_DIV1, ST_DIV2, ST_DIV3: begin
          // A zero divisor idles for the full slot so result latency never varies.
          if (!r_dvz) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
          end
          if (r_iter == ITER_W'(DIV_ITER - 1)) begin
            r_iter            <= '0;
            r_quot[w_div_idx] <= r_dvz ? '0 : w_quo_nx;
            if (r_state == ST_DIV3) begin
              r_state <= ST_CMP;
            end else begin
              r_quo   <= w_dividend;
              r_rem   <= '0;
              r_den   <= w_den;
              r_dvz   <= (w_den == '0);
              r_state <= state_t'(r_state + 3'd1);
            end
          end else begin
            r_iter <= r_iter + ITER_W'(1);
          end
        end
        ST_CMP: begin
          r_cmp_ipc    <= w_ipc_sat;
          r_cmp_cache  <= w_cache_pm;
          r_cmp_branch <= w_branch_pm;
          r_cmp_stall  <= w_stall_pm;
          r_cmp_flags  <= {w_ipc_sat < IPC_LOW_TH, w_cache_pm > CACHE_TH,
                           w_branch_pm > BRANCH_TH, w_stall_pm > STALL_TH};
          r_state      <= ST_PUB;
        end
        ST_PUB:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // A publish wins over a same-cycle acceptance; publishing over an unaccepted result is an overrun.
      if (r_state == ST_PUB) begin
        r_valid     <= 1'b1;
        r_ipc       <= r_cmp_ipc;
        r_cache_pm  <= r_cmp_cache;
        r_branch_pm <= r_cmp_branch;
        r_stall_pm  <= r_cmp_stall;
        r_flags     <= r_cmp_flags;
        if (r_valid && !result.result_ready_i) r_overrun <= 1'b1;
      end else if (r_valid && result.result_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign result.result_valid_o     = r_valid;
  assign result.overrun_o          = r_overrun;
  assign result.ipc_o              = r_ipc;
  assign result.cache_miss_pm_o    = r_cache_pm;
  assign result.branch_miss_pm_o   = r_branch_pm;
  assign result.stall_pm_o         = r_stall_pm;
  assign result.ipc_low_o          = r_flags[3];
  assign result.cache_miss_high_o  = r_flags[2];
  assign result.branch_miss_high_o = r_flags[1];
  assign result.stall_high_o       = r_flags[0];

endmodule
